// File: rtl/sc_transition_pkg.sv
// Shared definitions for the pushbutton transition-pulse stage.
// State encoding and default timing/width parameters.
package sc_transition_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // 20 ms debounce at 50 MHz
  localparam int unsigned DEF_DEBOUNCE_CYCLES  = 1000000;
  localparam int unsigned DEF_DEBOUNCE_WIDTH   = 20;
  // 2 s long-press at 50 MHz
  localparam int unsigned DEF_LONGPRESS_CYCLES = 100000000;
  localparam int unsigned DEF_LONGPRESS_WIDTH  = 27;

endpackage

// File: rtl/sc_sync2.sv
// Two-flop synchronizer for an asynchronous active-low input.
// Both flops reset to 1 (released level) so a button held through reset
// is seen as a fresh press once reset is removed.
module sc_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw input through two flops; async reset to the idle level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sc_transition_pulse_gen.sv
// Pushbutton conditioning stage for the up-transition counter.
// Synchronizes and debounces one active-low button, emits one active-low
// count pulse per accepted press and exports the debounced level.
// Optional long-press clear pulse: define TRANSITION_LONGPRESS_CLEAR_EN.
module sc_transition_pulse_gen
  import sc_transition_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned DEBOUNCE_WIDTH   = DEF_DEBOUNCE_WIDTH,
  parameter int unsigned LONGPRESS_CYCLES = DEF_LONGPRESS_CYCLES,
  parameter int unsigned LONGPRESS_WIDTH  = DEF_LONGPRESS_WIDTH
) (
  input  logic SC_upTRANSITIONCOUNTER_CLOCK_50,
  input  logic SC_upTRANSITIONCOUNTER_RESET_InHigh,
  input  logic SC_TRANSITIONPULSE_button_InLow,
  output logic SC_TRANSITIONPULSE_pulse_OutLow,
  output logic SC_TRANSITIONPULSE_clear_OutLow,
  output logic SC_TRANSITIONPULSE_level_OutLow
);

  localparam logic [DEBOUNCE_WIDTH-1:0] CNT_LAST = DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                      clk;
  logic                      rst;
  logic                      sync;
  state_t                    state;
  state_t                    state_nxt;
  logic [DEBOUNCE_WIDTH-1:0] cnt;
  logic [DEBOUNCE_WIDTH-1:0] cnt_nxt;
  logic                      pulse_q;
  logic                      pulse_nxt;
  logic                      level_q;
  logic                      level_nxt;

  assign clk = SC_upTRANSITIONCOUNTER_CLOCK_50;
  assign rst = SC_upTRANSITIONCOUNTER_RESET_InHigh;

  sc_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (SC_TRANSITIONPULSE_button_InLow),
    .q   (sync)
  );

  // Next-state, stability counter and registered-output decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b1;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!sync) state_nxt = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (sync) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          pulse_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + DEBOUNCE_WIDTH'(1);
        end
      end
      PRESSED: begin
        cnt_nxt = '0;
        if (sync) state_nxt = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (!sync) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + DEBOUNCE_WIDTH'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // Level is registered from the next state so it changes on the same
    // edge as the press pulse.
    level_nxt = !((state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT));
  end

  // State, counter and output registers with async reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pulse_q <= 1'b1;
      level_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pulse_q <= pulse_nxt;
      level_q <= level_nxt;
    end
  end

  assign SC_TRANSITIONPULSE_pulse_OutLow = pulse_q;
  assign SC_TRANSITIONPULSE_level_OutLow = level_q;

`ifdef TRANSITION_LONGPRESS_CLEAR_EN
  localparam logic [LONGPRESS_WIDTH-1:0] LP_LAST = LONGPRESS_WIDTH'(LONGPRESS_CYCLES - 1);
  localparam logic [LONGPRESS_WIDTH-1:0] LP_HOLD = LONGPRESS_WIDTH'(LONGPRESS_CYCLES);

  logic [LONGPRESS_WIDTH-1:0] lp_cnt;
  logic [LONGPRESS_WIDTH-1:0] lp_nxt;
  logic                       clear_q;
  logic                       clear_nxt;

  // Long-press counter: fires once at LP_LAST, then parks at LP_HOLD so a
  // continued hold (including release bounces) never re-fires.
  always_comb begin
    lp_nxt    = lp_cnt;
    clear_nxt = 1'b1;
    if ((state == IDLE) || ((state == PRESS_WAIT) && (state_nxt == PRESSED))) begin
      lp_nxt = '0;
    end else if ((state == PRESSED) || (state == RELEASE_WAIT)) begin
      if (lp_cnt == LP_LAST) begin
        clear_nxt = 1'b0;
        lp_nxt    = LP_HOLD;
      end else if (lp_cnt != LP_HOLD) begin
        lp_nxt = lp_cnt + LONGPRESS_WIDTH'(1);
      end
    end
  end

  // Long-press counter and clear output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lp_cnt  <= '0;
      clear_q <= 1'b1;
    end else begin
      lp_cnt  <= lp_nxt;
      clear_q <= clear_nxt;
    end
  end

  assign SC_TRANSITIONPULSE_clear_OutLow = clear_q;
`else
  // Long-press parameters stay on the interface for drop-in compatibility;
  // folding them into the constant keeps them referenced.
  localparam bit LP_CFG_SEEN = (LONGPRESS_CYCLES >= 1) || (LONGPRESS_WIDTH >= 1);

  assign SC_TRANSITIONPULSE_clear_OutLow = LP_CFG_SEEN | 1'b1;
`endif

endmodule

// File: tb/tb_sc_transition_pulse_gen.sv
// Directed bench for sc_transition_pulse_gen with DEBOUNCE_CYCLES=4 and
// LONGPRESS_CYCLES=20. Edge k counts rising edges from the first one that
// samples the raw button low.
module tb_sc_transition_pulse_gen;

  logic clk = 1'b0;
  logic rst;
  logic raw;
  logic pulse;
  logic clear;
  logic level;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  int          ds_count = 0;

  typedef struct {
    logic raw;
    logic pulse;
    logic level;
  } vec_t;

  vec_t tbl [14];

  always #5 clk = ~clk;

  sc_transition_pulse_gen #(
    .DEBOUNCE_CYCLES  (4),
    .DEBOUNCE_WIDTH   (20),
    .LONGPRESS_CYCLES (20),
    .LONGPRESS_WIDTH  (27)
  ) dut (
    .SC_upTRANSITIONCOUNTER_CLOCK_50     (clk),
    .SC_upTRANSITIONCOUNTER_RESET_InHigh (rst),
    .SC_TRANSITIONPULSE_button_InLow     (raw),
    .SC_TRANSITIONPULSE_pulse_OutLow     (pulse),
    .SC_TRANSITIONPULSE_clear_OutLow     (clear),
    .SC_TRANSITIONPULSE_level_OutLow     (level)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive raw, advance one rising edge, sample 1 time unit later and update
  // the model of the downstream counter (clear wins over count).
  task automatic cyc(input logic v);
    raw = v;
    @(posedge clk);
    #1;
    if (clear === 1'b0) ds_count = 0;
    else if (pulse === 1'b0) ds_count++;
  endtask

  task automatic do_reset();
    raw = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    ds_count = 0;
  endtask

  initial begin
    int np;
    int nc;
    int nl;
    int pe;
    int ce;

    tbl = '{
      '{1'b0, 1'b1, 1'b1},  // edge 1
      '{1'b0, 1'b1, 1'b1},
      '{1'b0, 1'b1, 1'b1},
      '{1'b0, 1'b1, 1'b1},
      '{1'b0, 1'b1, 1'b1},
      '{1'b0, 1'b1, 1'b1},
      '{1'b0, 1'b0, 1'b0},  // edge 7: pulse, level goes low
      '{1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b0}   // edge 14
    };

    // Reset state
    do_reset();
    chk("reset_pulse", int'(pulse), 1);
    chk("reset_level", int'(level), 1);
    chk("reset_clear", int'(clear), 1);
    repeat (3) cyc(1'b1);
    chk("idle_level", int'(level), 1);

    // Clean press: table for edges 1..14, then hold to edge 40
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].raw);
      chk($sformatf("press_pulse_e%0d", i + 1), int'(pulse), int'(tbl[i].pulse));
      chk($sformatf("press_level_e%0d", i + 1), int'(level), int'(tbl[i].level));
      if (i == 5) chk("ds_before", ds_count, 0);
      if (i == 6) chk("ds_after", ds_count, 1);
    end
    np = 0; nc = 0; nl = 0; ce = 0;
    for (int k = 15; k <= 40; k++) begin
      cyc(1'b0);
      if (pulse === 1'b0) np++;
      if (level !== 1'b0) nl++;
      if (clear === 1'b0) begin nc++; ce = k; end
    end
    chk("hold_no_repulse", np, 0);
    chk("hold_level_low", nl, 0);
`ifdef TRANSITION_LONGPRESS_CLEAR_EN
    chk("hold_clear_count", nc, 1);
    chk("hold_clear_edge", ce, 27);
    chk("hold_ds_cleared", ds_count, 0);
`else
    chk("hold_clear_count", nc, 0);
    chk("hold_ds_count", ds_count, 1);
`endif
    repeat (10) cyc(1'b1);
    chk("release_level", int'(level), 1);

    // Press bounce: low 2, high 1, low 2, then high
    np = 0; nl = 0;
    cyc(1'b0); cyc(1'b0); cyc(1'b1); cyc(1'b0); cyc(1'b0);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1);
      if (pulse === 1'b0) np++;
      if (level === 1'b0) nl++;
    end
    chk("bounce_no_pulse", np, 0);
    chk("bounce_level_high", nl, 0);
    // Back in IDLE with a cleared counter: next clean press pulses at edge 7
    np = 0; pe = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b0);
      if (pulse === 1'b0) begin np++; pe = k; end
    end
    chk("after_bounce_pulses", np, 1);
    chk("after_bounce_edge", pe, 7);
    repeat (10) cyc(1'b1);

    // Release bounce: accepted press, toggle every 2 cycles, then stay low
    np = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b0);
      if (pulse === 1'b0) np++;
    end
    chk("rb_first_pulse", np, 1);
    np = 0; nl = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(((k / 2) % 2 == 0) ? 1'b1 : 1'b0);
      if (pulse === 1'b0) np++;
      if (level !== 1'b0) nl++;
    end
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0);
      if (pulse === 1'b0) np++;
      if (level !== 1'b0) nl++;
    end
    chk("rb_no_second_pulse", np, 0);
    chk("rb_level_low", nl, 0);
    repeat (12) cyc(1'b1);
    chk("rb_release_level", int'(level), 1);

    // Ten clean presses separated by 10-cycle releases
    do_reset();
    np = 0; nc = 0;
    for (int p = 0; p < 10; p++) begin
      for (int k = 0; k < 8; k++) begin
        cyc(1'b0);
        if (pulse === 1'b0) np++;
        if (clear === 1'b0) nc++;
      end
      for (int k = 0; k < 10; k++) begin
        cyc(1'b1);
        if (pulse === 1'b0) np++;
      end
    end
    chk("ten_pulses", np, 10);
    chk("ten_ds_count", ds_count, 10);
    chk("ten_no_clear", nc, 0);

    // Reset asserted while the pulse is low, raw held low through reset
    for (int k = 1; k <= 7; k++) cyc(1'b0);
    chk("mid_pulse_low", int'(pulse), 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_pulse", int'(pulse), 1);
    chk("mid_rst_level", int'(level), 1);
    chk("mid_rst_clear", int'(clear), 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b0);
      chk($sformatf("post_rst_pulse_e%0d", k), int'(pulse), (k == 7) ? 0 : 1);
      chk($sformatf("post_rst_level_e%0d", k), int'(level), (k >= 7) ? 0 : 1);
    end
    repeat (10) cyc(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
